// File: rtl/div_stall_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// It holds the pipeline stalled while dividing, then presents HI/LO for one unstalled cycle.
module div_stall_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stallreq_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dvs_abs;
  logic             q_neg, r_neg;

  logic             start_fire, last_step;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   rem_shifted, trial;
  logic [WIDTH-1:0] quo_step, rem_step;

  // A start is only accepted from IDLE; a start seen in DONE belongs to the departing instruction.
  assign start_fire = (state == IDLE) && div_start && !annul;
  assign last_step  = (cnt == CNT_W'(WIDTH - 1));

  // Operand magnitudes; the unsigned path passes operands through untouched.
  always_comb begin
    dvd_mag = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // One restoring step. The partial remainder is always below the divisor, so the shifted
  // remainder fits WIDTH+1 bits and the trial MSB is a reliable sign bit.
  always_comb begin
    rem_shifted = {rem, quo[WIDTH-1]};
    trial       = rem_shifted - {1'b0, dvs_abs};
    quo_step    = {quo[WIDTH-2:0], ~trial[WIDTH]};
    rem_step    = trial[WIDTH] ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (div_start) state_nxt = (divisor == '0) ? DONE : BUSY;
      BUSY: if (last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  always_comb begin
    stallreq_div = !annul && (((state == IDLE) && div_start) || (state == BUSY));
    result_valid = (state == DONE);
  end

  // Datapath. The shift registers are reset too, so a cancelled operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs_abs     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (start_fire) begin
      cnt     <= '0;
      quo     <= dvd_mag;
      rem     <= '0;
      dvs_abs <= dvs_mag;
      q_neg   <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg   <= div_signed && dividend[WIDTH-1];
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if ((state == BUSY) && !annul) begin
      cnt <= cnt + CNT_W'(1);
      quo <= quo_step;
      rem <= rem_step;
      if (last_step) begin
        quotient    <= q_neg ? -quo_step : quo_step;
        remainder   <= r_neg ? -rem_step : rem_step;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Self-checking bench for div_stall_unit: directed test-plan cases plus randomized divides
// checked against an arithmetic reference model of DIV/DIVU.
module tb_div_stall_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             annul;
  logic             stallreq_div;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] last_q, last_r;
  logic             last_dz;

  div_stall_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .stallreq_div (stallreq_div),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: magnitudes divided with plain integer arithmetic, signs reapplied.
  task automatic ref_div(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                         output logic dz);
    logic [WIDTH-1:0] ua, ub, uq, ur;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      ua = (sgn && a[WIDTH-1]) ? (~a + 1) : a;
      ub = (sgn && b[WIDTH-1]) ? (~b + 1) : b;
      uq = ua / ub;
      ur = ua % ub;
      q  = (sgn && (a[WIDTH-1] != b[WIDTH-1])) ? (~uq + 1) : uq;
      r  = (sgn && a[WIDTH-1]) ? (~ur + 1) : ur;
      dz = 1'b0;
    end
  endtask

  // Called at posedge+1. Applies a divide, counts stall cycles, checks the result pulse.
  // keep=1 leaves div_start high through DONE so the caller can launch a back-to-back op.
  task automatic run_div(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic keep, input logic drop_mid);
    logic [WIDTH-1:0] eq, er;
    logic             edz, got;
    int               stall_cnt;
    ref_div(sgn, a, b, eq, er, edz);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    stall_cnt  = 0;
    got        = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      if (stallreq_div) stall_cnt++;
      if (drop_mid && stall_cnt == 5) div_start = 1'b0;
    end
    check("result_seen", 64'(got), 64'(1));
    check("stall_cycles", 64'(stall_cnt), (b == 0) ? 64'(1) : 64'(WIDTH + 1));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    check("stall_in_done", 64'(stallreq_div), 64'(0));
    last_q  = eq;
    last_r  = er;
    last_dz = edz;
    @(posedge clk);
    #1;
    if (!keep || drop_mid) begin
      div_start = 1'b0;
      @(negedge clk);
      check("rv_single_pulse", 64'(result_valid), 64'(0));
      check("stall_idle", 64'(stallreq_div), 64'(0));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic             seen;
    logic             sgn, keep, drop;
    logic [WIDTH-1:0] a, b;

    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    annul      = 1'b0;
    last_q     = '0;
    last_r     = '0;
    last_dz    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_dz", 64'(div_by_zero), 64'(0));
    check("rst_rv", 64'(result_valid), 64'(0));
    check("rst_stall", 64'(stallreq_div), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases from the plan.
    run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_div(1'b0, 32'd1234, 32'd0, 1'b0, 1'b0);
    // Back-to-back: start stays high through DONE, then the next op starts from IDLE.
    run_div(1'b0, 32'd1000, 32'd33, 1'b1, 1'b0);
    run_div(1'b1, 32'hFFFF_FC18, 32'd33, 1'b0, 1'b0);
    // Start dropped mid-operation: the divide still completes.
    run_div(1'b0, 32'hDEAD_BEEF, 32'd12345, 1'b0, 1'b1);

    // Annul on BUSY cycle 10: stall released at once, no result, outputs untouched.
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    div_start  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stallreq_div), 64'(0));
    @(posedge clk);
    #1;
    annul     = 1'b0;
    div_start = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid || stallreq_div) seen = 1'b1;
    end
    check("annul_no_result", 64'(seen), 64'(0));
    check("annul_q_kept", 64'(quotient), 64'(last_q));
    check("annul_r_kept", 64'(remainder), 64'(last_r));
    check("annul_dz_kept", 64'(div_by_zero), 64'(last_dz));

    // Same abort with rst: every output returns to zero.
    @(posedge clk);
    #1;
    div_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    check("mid_rst_quotient", 64'(quotient), 64'(0));
    check("mid_rst_remainder", 64'(remainder), 64'(0));
    check("mid_rst_dz", 64'(div_by_zero), 64'(0));
    check("mid_rst_rv", 64'(result_valid), 64'(0));
    check("mid_rst_stall", 64'(stallreq_div), 64'(0));
    @(posedge clk);
    #1;

    // Randomized divides, including zero, -1 and most-negative corner operands.
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom % 2);
      a   = $urandom;
      if ($urandom % 8 == 0) a = 32'h8000_0000;
      case ($urandom % 8)
        0:       b = '0;
        1:       b = '1;
        2, 3:    b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      keep = (n != 39) && ($urandom % 4 == 0);
      drop = (b != 0) && ($urandom % 4 == 0);
      run_div(sgn, a, b, keep, drop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
